// File: rtl/sequenciador_tela.sv
// Screen sequencer for the OLED pet: resolves button presses, tracks fome/feliz and paces
// frames to the display controller. Optional macro ALERTA_TRISTE_EN enables the sad screen.
module sequenciador_tela #(
  parameter int COMBO_WIN     = 16,
  parameter int HOLD_FRAMES   = 8,
  parameter int DECAY_DIV     = 12000000,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       b1_evt,
  input  logic       b2_evt,
  input  logic       frame_done,
  output logic       frame_req,
  output logic [3:0] estado,
  output logic [2:0] fome,
  output logic [2:0] feliz,
  output logic       err_timeout,
  output logic [1:0] dbg_fsm_state,
  output logic [1:0] dbg_cap_state
);

  // Handshake: frame_req rises in REQ and stays high through WAIT until frame_done is
  // sampled in WAIT or the timeout expires; estado never changes while frame_req is high.

  localparam int WIN_W  = (COMBO_WIN > 0) ? $clog2(COMBO_WIN + 1) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int TMO_W  = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam int DEC_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(COMBO_WIN);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_FRAMES);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(FRAME_TIMEOUT - 1);
  localparam logic [DEC_W-1:0]  DEC_LAST  = DEC_W'(DECAY_DIV - 1);

  localparam logic [3:0] SCR_NORMAL = 4'b0000;
  localparam logic [3:0] SCR_EAT    = 4'b0001;
  localparam logic [3:0] SCR_PLAY   = 4'b0010;
  localparam logic [3:0] SCR_SLEEP  = 4'b0100;
  localparam logic [3:0] SCR_SAD    = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fsm_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WIN  = 2'd1,
    C_RES  = 2'd2
  } cap_e;

  fsm_e              state_q, state_d;
  cap_e              cap_q, cap_d;
  logic              first_b2_q, first_b2_d;
  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [3:0]        pend_code_q, pend_code_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DEC_W-1:0]  dec_q, dec_d;
  logic              tick_pend_q, tick_pend_d;
  logic [3:0]        estado_q, estado_d;
  logic [2:0]        fome_q, fome_d;
  logic [2:0]        feliz_q, feliz_d;
  logic              err_q, err_d;

  logic              commit;
  logic              other_btn;
  logic              tick_raw;
  logic              tick_due;
  logic [3:0]        normal_scr;

  function automatic logic [2:0] sat_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[3] ? 3'd7 : s[2:0];
  endfunction

  function automatic logic [2:0] sat_sub(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? 3'd0 : (a - b);
  endfunction

`ifdef ALERTA_TRISTE_EN
  assign normal_scr = ((fome_q == 3'd7) || (feliz_q == 3'd0)) ? SCR_SAD : SCR_NORMAL;
`else
  assign normal_scr = SCR_NORMAL;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (frame_done || (tmo_q == TMO_LAST)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; an action is only taken once the previous one has shown all its frames
  always_comb begin
    frame_req = (state_q == S_REQ) || (state_q == S_WAIT);
    commit    = (state_q == S_IDLE) && (hold_q == '0) && (cap_q == C_RES);
  end

  // Button capture: a window after the first press decides single versus combo
  always_comb begin
    cap_d       = cap_q;
    first_b2_d  = first_b2_q;
    win_cnt_d   = win_cnt_q;
    pend_code_d = pend_code_q;
    other_btn   = first_b2_q ? b1_evt : b2_evt;
    case (cap_q)
      C_IDLE: begin
        if (b1_evt && b2_evt) begin
          cap_d       = C_RES;
          pend_code_d = SCR_SLEEP;
        end else if (b1_evt || b2_evt) begin
          cap_d      = C_WIN;
          first_b2_d = b2_evt;
          win_cnt_d  = WIN_W'(1);
        end
      end
      C_WIN: begin
        if (other_btn) begin
          cap_d       = C_RES;
          pend_code_d = SCR_SLEEP;
        end else if (win_cnt_q == WIN_LAST) begin
          cap_d       = C_RES;
          pend_code_d = first_b2_q ? SCR_PLAY : SCR_EAT;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
        end
      end
      C_RES: begin
        if (commit) begin
          cap_d = C_IDLE;
        end
      end
      default: cap_d = C_IDLE;
    endcase
  end

  // Frame datapath: estado only moves on the IDLE edge
  always_comb begin
    estado_d = estado_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (commit) begin
          estado_d = pend_code_q;
          hold_d   = HOLD_INIT;
        end else if (hold_q == '0) begin
          estado_d = normal_scr;
        end
      end
      S_REQ: tmo_d = TMO_W'(1);
      S_WAIT: begin
        if (frame_done) begin
          if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Stats: a decay tick that collides with a commit is carried to the next cycle
  always_comb begin
    tick_raw    = (dec_q == DEC_LAST);
    dec_d       = tick_raw ? '0 : dec_q + 1'b1;
    tick_due    = tick_raw || tick_pend_q;
    fome_d      = fome_q;
    feliz_d     = feliz_q;
    tick_pend_d = 1'b0;
    if (commit) begin
      tick_pend_d = tick_due;
      case (pend_code_q)
        SCR_EAT:  fome_d = sat_sub(fome_q, 3'd2);
        SCR_PLAY: begin
          feliz_d = sat_add(feliz_q, 3'd2);
          fome_d  = sat_add(fome_q, 3'd1);
        end
        SCR_SLEEP: feliz_d = sat_add(feliz_q, 3'd1);
        default: ;
      endcase
    end else if (tick_due) begin
      fome_d  = sat_add(fome_q, 3'd1);
      feliz_d = sat_sub(feliz_q, 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q       <= C_IDLE;
      first_b2_q  <= 1'b0;
      win_cnt_q   <= '0;
      pend_code_q <= SCR_NORMAL;
      hold_q      <= '0;
      tmo_q       <= '0;
      dec_q       <= '0;
      tick_pend_q <= 1'b0;
      estado_q    <= SCR_NORMAL;
      fome_q      <= 3'd0;
      feliz_q     <= 3'd7;
      err_q       <= 1'b0;
    end else begin
      cap_q       <= cap_d;
      first_b2_q  <= first_b2_d;
      win_cnt_q   <= win_cnt_d;
      pend_code_q <= pend_code_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      dec_q       <= dec_d;
      tick_pend_q <= tick_pend_d;
      estado_q    <= estado_d;
      fome_q      <= fome_d;
      feliz_q     <= feliz_d;
      err_q       <= err_d;
    end
  end

  assign estado        = estado_q;
  assign fome          = fome_q;
  assign feliz         = feliz_q;
  assign err_timeout   = err_q;
  assign dbg_fsm_state = state_q;
  assign dbg_cap_state = cap_q;

endmodule

// File: tb/tb_sequenciador_tela.sv
// Bench for sequenciador_tela: random and directed button/frame traffic checked each cycle
// against a behavioural model built from event timestamps and frame intervals.
module tb_sequenciador_tela;

  localparam int CW  = 16;
  localparam int HF  = 8;
  localparam int DIV = 300;
  localparam int FT  = 500;
  localparam int EAT = 1, PLAY = 2, SLEEP = 4;
`ifdef ALERTA_TRISTE_EN
  localparam bit ALERT_EN = 1'b1;
`else
  localparam bit ALERT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       b1_evt = 1'b0;
  logic       b2_evt = 1'b0;
  logic       frame_done = 1'b0;
  logic       frame_req;
  logic [3:0] estado;
  logic [2:0] fome;
  logic [2:0] feliz;
  logic       err_timeout;
  logic [1:0] dbg_fsm_state;
  logic [1:0] dbg_cap_state;

  sequenciador_tela #(
    .COMBO_WIN(CW), .HOLD_FRAMES(HF), .DECAY_DIV(DIV), .FRAME_TIMEOUT(FT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .b1_evt(b1_evt), .b2_evt(b2_evt),
    .frame_done(frame_done), .frame_req(frame_req), .estado(estado),
    .fome(fome), .feliz(feliz), .err_timeout(err_timeout),
    .dbg_fsm_state(dbg_fsm_state), .dbg_cap_state(dbg_cap_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // behavioural model state
  int  m_fome, m_feliz, m_estado, m_err, m_hold;
  bit  fr_active;
  int  fr_start;
  bit  win_open;
  int  win_btn, win_t0;
  int  pend_q[$];
  int  ticks_owed;
  logic [3:0] exp_q[$];

  // responder state
  int  req_age = 0;
  int  cur_dly = 0;
  bit  fd_next = 1'b0;
  bit  prev_req = 1'b0;
  int  dly_mode = 0;
  int  fix_dly = 50;
  bit  spur_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 7) ? 7 : v);
  endfunction

  function automatic int normal_screen(input int f, input int h);
    return (ALERT_EN && (f == 7 || h == 0)) ? 8 : 0;
  endfunction

  task automatic model_reset();
    m_fome = 0; m_feliz = 7; m_estado = 0; m_err = 0; m_hold = 0;
    fr_active = 0; fr_start = 0; win_open = 0; win_btn = 0; win_t0 = 0;
    pend_q.delete(); exp_q.delete(); ticks_owed = 0;
  endtask

  // One clock edge of the reference behaviour, e = edge index since reset release
  task automatic model_edge(input int e, input bit b1, input bit b2, input bit fd);
    bit had_pend, commit;
    int act;
    had_pend = (pend_q.size() != 0);
    commit = 0;
    act = 0;
    if (fr_active) begin
      if (fd && e >= fr_start + 2) begin
        fr_active = 0;
        if (m_hold > 0) m_hold--;
      end else if (e == fr_start + FT) begin
        fr_active = 0;
        m_err = 1;
      end
    end else begin
      if (m_hold == 0) begin
        if (had_pend) begin
          act = pend_q.pop_front();
          m_estado = act;
          m_hold = HF;
          commit = 1;
        end else begin
          m_estado = normal_screen(m_fome, m_feliz);
        end
      end
      exp_q.push_back(4'(m_estado));
      fr_active = 1;
      fr_start = e;
    end
    if (!had_pend) begin
      if (win_open) begin
        if ((win_btn == 1) ? b2 : b1) begin
          pend_q.push_back(SLEEP);
          win_open = 0;
        end else if (e == win_t0 + CW) begin
          pend_q.push_back((win_btn == 1) ? EAT : PLAY);
          win_open = 0;
        end
      end else if (b1 && b2) begin
        pend_q.push_back(SLEEP);
      end else if (b1 || b2) begin
        win_open = 1;
        win_btn = b1 ? 1 : 2;
        win_t0 = e;
      end
    end
    if (e % DIV == 0) ticks_owed++;
    if (commit) begin
      if (act == EAT) m_fome = sat(m_fome - 2);
      else if (act == PLAY) begin
        m_feliz = sat(m_feliz + 2);
        m_fome = sat(m_fome + 1);
      end else m_feliz = sat(m_feliz + 1);
    end else if (ticks_owed > 0) begin
      ticks_owed--;
      m_fome = sat(m_fome + 1);
      m_feliz = sat(m_feliz - 1);
    end
  endtask

  function automatic int pick_delay();
    int r;
    if (dly_mode == 0) return fix_dly;
    r = $urandom_range(0, 19);
    if (r == 0) return -1;
    if (r == 1) return 1;
    return $urandom_range(2, 60);
  endfunction

  // driver: one clock with the given button pulses, then compare against the model
  task automatic run_cycle(input logic b1v, input logic b2v);
    logic [3:0] exp_scr;
    b1_evt = b1v;
    b2_evt = b2v;
    frame_done = fd_next;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(cyc, b1v, b2v, fd_next);
    check_val("frame_req", frame_req, fr_active);
    check_val("estado", estado, m_estado);
    check_val("fome", fome, m_fome);
    check_val("feliz", feliz, m_feliz);
    check_val("err_timeout", err_timeout, m_err);
    if (frame_req && !prev_req) begin
      check_val("frm_cnt", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        exp_scr = exp_q.pop_front();
        check_val("frm_estado", estado, exp_scr);
      end
    end
    prev_req = frame_req;
    if (frame_req) begin
      req_age++;
      if (req_age == 1) cur_dly = pick_delay();
      fd_next = (cur_dly > 0) && (req_age == cur_dly);
    end else begin
      req_age = 0;
      fd_next = spur_en && ($urandom_range(0, 9) == 0);
    end
    b1_evt = 1'b0;
    b2_evt = 1'b0;
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    b1_evt = 1'b0;
    b2_evt = 1'b0;
    frame_done = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check_val("rst_frame_req", frame_req, 0);
      check_val("rst_estado", estado, 0);
      check_val("rst_fome", fome, 0);
      check_val("rst_feliz", feliz, 7);
      check_val("rst_err", err_timeout, 0);
    end
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
    req_age = 0;
    fd_next = 1'b0;
    prev_req = 1'b0;
  endtask

  task automatic wait_in_frame(input string tag, input int age);
    for (int i = 0; i < 3000 && !(frame_req && req_age >= age); i++) run_cycle(1'b0, 1'b0);
    check_val(tag, (frame_req && req_age >= age), 1);
  endtask

  initial begin
    do_reset(3);

    // single press on b1, frames complete 50 cycles after each request
    dly_mode = 0; fix_dly = 50;
    run_idle(20);
    run_cycle(1'b1, 1'b0);
    run_idle(800);

    // combo: b2 then b1 five cycles later
    run_cycle(1'b0, 1'b1);
    run_idle(4);
    run_cycle(1'b1, 1'b0);
    run_idle(800);

    // both buttons in the same cycle, plus a repeat of b1 inside a window
    run_cycle(1'b1, 1'b1);
    run_idle(800);
    run_cycle(1'b1, 1'b0);
    run_idle(3);
    run_cycle(1'b1, 1'b0);
    run_idle(800);

    // press during a long frame: estado must wait for frame_done
    fix_dly = 200;
    wait_in_frame("tear_wait", 20);
    run_cycle(1'b0, 1'b1);
    run_idle(2500);

    // randomized traffic with random frame latencies and stray frame_done pulses
    dly_mode = 1; spur_en = 1'b1;
    for (int i = 0; i < 12000; i++)
      run_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 59) == 0));
    check_val("frm_left", exp_q.size(), 0);

    // reset in the middle of a frame
    dly_mode = 0; fix_dly = 100; spur_en = 1'b0;
    wait_in_frame("midreset_wait", 10);
    do_reset(1);
    run_idle(50);

    // timeout and decay: frame_done never arrives
    fix_dly = -1;
    do_reset(3);
    run_idle(FT);
    check_val("tmo_req_hi", frame_req, 1);
    check_val("tmo_err_lo", err_timeout, 0);
    run_idle(1);
    check_val("tmo_req_lo", frame_req, 0);
    check_val("tmo_err_hi", err_timeout, 1);
    run_idle(2600 - cyc);
    check_val("decay_fome", fome, 7);
    check_val("decay_feliz", feliz, 0);
    check_val("decay_estado", estado, ALERT_EN ? 8 : 0);
    check_val("frm_left_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
